// File: rtl/locked_reg_unlock_ctrl_if.sv
// Handshake and register-side bundle for locked_reg_unlock_ctrl.
// The master side supplies keys and write requests; the slave side is the controller.
interface locked_reg_unlock_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             key_valid;
    logic [WIDTH-1:0] key_data;
    logic             req_valid;
    logic [WIDTH-1:0] req_data;
    logic             req_ready;
    logic             write_en;
    logic [WIDTH-1:0] data_out;
    logic             unlocked;
    logic             lockout;
    logic [3:0]       fail_count;
    logic             viol;

    modport master (
        output key_valid, key_data, req_valid, req_data,
        input  req_ready, write_en, data_out, unlocked, lockout, fail_count, viol
    );

    modport slave (
        input  key_valid, key_data, req_valid, req_data,
        output req_ready, write_en, data_out, unlocked, lockout, fail_count, viol
    );
endinterface

// File: rtl/locked_reg_unlock_ctrl.sv
// Key-sequence gated write controller for a locked register; lockout after MAX_FAIL bad keys.
// Optional macro UNLOCK_MULTI_WRITE_EN keeps the window open after each accepted write.
module locked_reg_unlock_ctrl #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] KEY0     = 8'hA5,
    parameter logic [WIDTH-1:0] KEY1     = 8'h3C,
    parameter int               MAX_FAIL = 3,
    parameter int               WINDOW   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    locked_reg_unlock_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_GOT_KEY0 = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_t;

    localparam logic [3:0] MAX_FAIL_C   = 4'(MAX_FAIL);
    localparam logic [7:0] WIN_RELOAD_C = 8'(WINDOW - 1);

    // Saturating increment so the counter can never wrap past the lockout threshold.
    function automatic logic [3:0] fail_sat_inc(input logic [3:0] cnt);
        logic [3:0] res;
        if (cnt >= MAX_FAIL_C) begin
            res = MAX_FAIL_C;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       fail_r;
    logic [3:0]       fail_nxt_s;
    logic [3:0]       fail_inc_val_s;
    logic             fail_inc_s;
    logic [7:0]       win_r;
    logic [7:0]       win_nxt_s;
    logic             accept_s;
    logic             viol_nxt_s;
    logic             write_en_r;
    logic [WIDTH-1:0] data_out_r;
    logic             viol_r;
    logic             unlocked_r;
    logic             lockout_r;

    // State, wrong-key counter and window counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_LOCKED;
            fail_r  <= 4'd0;
            win_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            fail_r  <= fail_nxt_s;
            win_r   <= win_nxt_s;
        end
    end

    // Next-state decode: key sequence, window countdown, request acceptance and lockout.
    always_comb begin
        state_nxt_s    = state_r;
        fail_nxt_s     = fail_r;
        win_nxt_s      = win_r;
        accept_s       = 1'b0;
        fail_inc_s     = 1'b0;
        fail_inc_val_s = fail_sat_inc(fail_r);
        viol_nxt_s     = bus.req_valid && (state_r != ST_UNLOCKED);

        case (state_r)
            ST_LOCKED: begin
                if (bus.key_valid) begin
                    if (bus.key_data == KEY0) begin
                        state_nxt_s = ST_GOT_KEY0;
                    end else begin
                        fail_inc_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            ST_GOT_KEY0: begin
                // No timeout here: the second key may arrive arbitrarily late.
                if (bus.key_valid) begin
                    if (bus.key_data == KEY1) begin
                        state_nxt_s = ST_UNLOCKED;
                        fail_nxt_s  = 4'd0;
                        win_nxt_s   = WIN_RELOAD_C;
                    end else begin
                        state_nxt_s = ST_LOCKED;
                        fail_inc_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_GOT_KEY0;
                end
            end
            ST_UNLOCKED: begin
                if (bus.req_valid) begin
                    accept_s = 1'b1;
`ifdef UNLOCK_MULTI_WRITE_EN
                    win_nxt_s   = WIN_RELOAD_C;
`else
                    state_nxt_s = ST_LOCKED;
                    win_nxt_s   = 8'd0;
`endif
                end else if (win_r == 8'd0) begin
                    state_nxt_s = ST_LOCKED;
                end else begin
                    win_nxt_s = win_r - 8'd1;
                end
            end
            ST_LOCKOUT: begin
                state_nxt_s = ST_LOCKOUT;
            end
            default: begin
                state_nxt_s = ST_LOCKOUT;
            end
        endcase

        // Reaching the threshold overrides whatever the case above chose.
        if (fail_inc_s) begin
            fail_nxt_s = fail_inc_val_s;
            if (fail_inc_val_s == MAX_FAIL_C) begin
                state_nxt_s = ST_LOCKOUT;
            end else begin
                state_nxt_s = state_nxt_s;
            end
        end else begin
            fail_nxt_s = fail_nxt_s;
        end
    end

    // Registered outputs; status flags track the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_en_r <= 1'b0;
            data_out_r <= {WIDTH{1'b0}};
            viol_r     <= 1'b0;
            unlocked_r <= 1'b0;
            lockout_r  <= 1'b0;
        end else begin
            write_en_r <= accept_s;
            if (accept_s) begin
                data_out_r <= bus.req_data;
            end else begin
                data_out_r <= data_out_r;
            end
            viol_r     <= viol_nxt_s;
            unlocked_r <= (state_nxt_s == ST_UNLOCKED);
            lockout_r  <= (state_nxt_s == ST_LOCKOUT);
        end
    end

    assign bus.req_ready  = unlocked_r;
    assign bus.unlocked   = unlocked_r;
    assign bus.lockout    = lockout_r;
    assign bus.write_en   = write_en_r;
    assign bus.data_out   = data_out_r;
    assign bus.fail_count = fail_r;
    assign bus.viol       = viol_r;

endmodule

// File: tb/tb_locked_reg_unlock_ctrl.sv
// Randomized bench for locked_reg_unlock_ctrl against a deadline-based reference model.
module tb_locked_reg_unlock_ctrl;

    localparam int         WINDOW   = 16;
    localparam int         MAX_FAIL = 3;
    localparam logic [7:0] KEY0     = 8'hA5;
    localparam logic [7:0] KEY1     = 8'h3C;
`ifdef UNLOCK_MULTI_WRITE_EN
    localparam bit MULTI = 1'b1;
`else
    localparam bit MULTI = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    locked_reg_unlock_ctrl_if #(.WIDTH(8)) bus ();

    locked_reg_unlock_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: unlock expressed as an absolute last-open cycle.
    int         m_cyc;
    int         m_deadline;
    bit         m_got0;
    bit         m_lockout;
    int         m_fail;
    bit         m_we;
    logic [7:0] m_data;
    bit         m_viol;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_deadline = -1;
        m_got0     = 1'b0;
        m_lockout  = 1'b0;
        m_fail     = 0;
        m_we       = 1'b0;
        m_data     = 8'h00;
        m_viol     = 1'b0;
    endtask

    task automatic model_step(input bit kv, input logic [7:0] kd, input bit rv, input logic [7:0] rd);
        bit open;
        open   = !m_lockout && (m_deadline >= m_cyc);
        m_viol = rv && !open;
        m_we   = rv && open;
        if (m_we) begin
            m_data     = rd;
            m_deadline = MULTI ? m_cyc + WINDOW : -1;
        end else if (!open && !m_lockout && kv) begin
            if (m_got0 && kd == KEY1) begin
                m_got0     = 1'b0;
                m_fail     = 0;
                m_deadline = m_cyc + WINDOW;
            end else if (!m_got0 && kd == KEY0) begin
                m_got0 = 1'b1;
            end else begin
                m_got0 = 1'b0;
                m_fail = m_fail + 1;
                if (m_fail >= MAX_FAIL) begin
                    m_fail    = MAX_FAIL;
                    m_lockout = 1'b1;
                end
            end
        end
        m_cyc++;
    endtask

    task automatic check_all(input string where);
        bit open;
        open = !m_lockout && (m_deadline >= m_cyc);
        chk({where, ".unlocked"},  32'(bus.unlocked),   32'(open));
        chk({where, ".req_ready"}, 32'(bus.req_ready),  32'(open));
        chk({where, ".lockout"},   32'(bus.lockout),    32'(m_lockout));
        chk({where, ".fail_cnt"},  32'(bus.fail_count), 32'(m_fail));
        chk({where, ".write_en"},  32'(bus.write_en),   32'(m_we));
        chk({where, ".data_out"},  32'(bus.data_out),   32'(m_data));
        chk({where, ".viol"},      32'(bus.viol),       32'(m_viol));
    endtask

    task automatic tick(input string where, input bit kv, input logic [7:0] kd,
                        input bit rv, input logic [7:0] rd);
        @(negedge clk);
        bus.key_valid = kv;
        bus.key_data  = kd;
        bus.req_valid = rv;
        bus.req_data  = rd;
        model_step(kv, kd, rv, rd);
        @(posedge clk);
        #1;
        check_all(where);
    endtask

    task automatic idle(input string where, input int n);
        for (int i = 0; i < n; i++) begin
            tick(where, 1'b0, 8'h00, 1'b0, 8'h00);
        end
    endtask

    // Reset raised between edges: outputs must clear before any clock edge.
    task automatic async_reset(input string where);
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.req_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all({where, ".async"});
        @(posedge clk);
        #1;
        check_all({where, ".held"});
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int pct;
        bit kv;
        bit rv;
        int sel;
        logic [7:0] kd;
        logic [7:0] rd;

        clk           = 1'b0;
        reset         = 1'b1;
        n_tests       = 0;
        n_fail        = 0;
        m_cyc         = 0;
        bus.key_valid = 1'b0;
        bus.key_data  = 8'h00;
        bus.req_valid = 1'b0;
        bus.req_data  = 8'h00;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Basic unlock and single write
        tick("k0",  1'b1, KEY0, 1'b0, 8'h00);
        tick("k1",  1'b1, KEY1, 1'b0, 8'h00);
        tick("wr",  1'b0, 8'h00, 1'b1, 8'h5E);
        idle("post_wr", 2);

        // Request while locked
        tick("lk_req", 1'b0, 8'h00, 1'b1, 8'h11);
        idle("lk_idle", 2);

        // Wrong keys into lockout, then valid keys must not unlock
        tick("bad0", 1'b1, 8'h00, 1'b0, 8'h00);
        tick("bad1", 1'b1, KEY0,  1'b0, 8'h00);
        tick("bad2", 1'b1, 8'h77, 1'b0, 8'h00);
        tick("bad3", 1'b1, 8'h12, 1'b0, 8'h00);
        tick("lo_k0", 1'b1, KEY0, 1'b0, 8'h00);
        tick("lo_k1", 1'b1, KEY1, 1'b0, 8'h00);
        tick("lo_req", 1'b0, 8'h00, 1'b1, 8'h42);
        async_reset("lo_clr");

        // Window expiry
        tick("w_k0", 1'b1, KEY0, 1'b0, 8'h00);
        tick("w_k1", 1'b1, KEY1, 1'b0, 8'h00);
        idle("w_idle", WINDOW + 2);
        tick("w_req", 1'b0, 8'h00, 1'b1, 8'h99);

        // Request on the final open cycle is still accepted
        tick("e_k0", 1'b1, KEY0, 1'b0, 8'h00);
        tick("e_k1", 1'b1, KEY1, 1'b0, 8'h00);
        idle("e_idle", WINDOW - 1);
        tick("e_req", 1'b0, 8'h00, 1'b1, 8'hC7);
        idle("e_post", 2);

        // Async reset mid-window, and just after an accepted write
        tick("r_k0", 1'b1, KEY0, 1'b0, 8'h00);
        tick("r_k1", 1'b1, KEY1, 1'b0, 8'h00);
        idle("r_idle", 4);
        async_reset("r_mid");
        tick("r_k1only", 1'b1, KEY1, 1'b0, 8'h00);
        tick("r_req", 1'b0, 8'h00, 1'b1, 8'h33);
        tick("r_k0b", 1'b1, KEY0, 1'b0, 8'h00);
        tick("r_k1b", 1'b1, KEY1, 1'b0, 8'h00);
        tick("r_wr", 1'b0, 8'h00, 1'b1, 8'hE1);
        async_reset("r_we");

        // Back-to-back requests
        tick("m_k0", 1'b1, KEY0, 1'b0, 8'h00);
        tick("m_k1", 1'b1, KEY1, 1'b0, 8'h00);
        tick("m_r1", 1'b0, 8'h00, 1'b1, 8'h01);
        tick("m_r2", 1'b0, 8'h00, 1'b1, 8'h02);
        tick("m_r3", 1'b0, 8'h00, 1'b1, 8'h03);
        idle("m_idle", WINDOW + 2);

        // Randomized segments, each starting from reset
        for (int seg = 0; seg < 24; seg++) begin
            async_reset("rnd_rst");
            case (seg % 3)
                0:       pct = 3;
                1:       pct = 12;
                default: pct = 45;
            endcase
            for (int c = 0; c < 150; c++) begin
                kv  = ($urandom_range(0, 2) == 0);
                sel = $urandom_range(0, 9);
                if (sel < 4)      kd = KEY0;
                else if (sel < 8) kd = KEY1;
                else              kd = 8'($urandom);
                rv  = ($urandom_range(0, 99) < pct);
                rd  = 8'($urandom);
                tick("rnd", kv, kd, rv, rd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
